sparse_repeat: RTL and testbench
================================

Name: sparse_repeat

Overview:
- Streaming sparse-tensor primitive.
- Replicates each reference token from proc_data_in once per repeat token on repsig_data_in. Emits the result on ref_data_out.
- Sits between a scanner/reference producer and downstream lookup blocks.
- All three stream ports use ready/valid with 17-bit tokens.

Parameters:
- DATA_WIDTH, 16, payload width; tokens are DATA_WIDTH+1 bits.
- OUT_FIFO_DEPTH, 2, output buffer depth in tokens.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-high (1 = reset); name kept per codebase
- clk_en  in  1  0 freezes all state and deasserts every ready/valid
- flush  in  1  synchronous clear, same effect as reset
- tile_en  in  1  0 holds block in reset state; all ready/valid low
- root  in  1  root mode: proc_data_in ignored
- spacc_mode  in  1  stop-filter enable
- stop_lvl  in  16  stop-level threshold for spacc_mode
- proc_data_in / _valid / _ready  in/in/out  17/1/1  reference token stream
- repsig_data_in / _valid / _ready  in/in/out  17/1/1  repeat-signal stream
- ref_data_out / _valid / _ready  out/out/in  17/1/1  output stream

Behaviour:
- Token format:
  - bit16=0: data, value in [15:0].
  - bit16=1, bit8=0: stop Sk, k in [7:0].
  - 0x10100: DONE.
  - On repsig, a data token means R (repeat).
- Reset/flush/tile_en=0:
  - FSM to START; output FIFO emptied; pending-stop flag cleared.
  - All valid/ready outputs 0; ref_data_out 0.
- Output path:
  - Tokens are written into OUT_FIFO_DEPTH FIFO.
  - ref_data_out_valid = FIFO non-empty.
  - Pop on valid && ready.
  - Latency: input heads valid at edge N -> token visible at output after edge N (1 cycle).
- Input consumption:
  - An input is popped only when its head is valid, the action below fires, and the FIFO is not full.
  - A same-cycle FIFO pop frees space.
  - Ready is asserted combinationally in exactly that cycle.
- Actions (non-root), by heads of ref and repsig:
  - ref data V, repsig R: flush any pending S0 first (see below); push V; pop repsig only.
  - ref data V, repsig S0: set pending-S0 flag; pop both; push nothing yet.
  - ref stop Sk: if pending S0, discard it; push S(k+1); pop ref only. If spacc_mode=1 and k < stop_lvl, drop the stop (push nothing) but still pop and clear pending.
  - ref data V with pending S0 set: push S0 first (one cycle), clear flag, then process V.
  - ref DONE and repsig DONE: push pending S0 if set, then push DONE, pop both, go to DONE state.
  - ref DONE with repsig non-DONE: stall (no pops). Repsig DONE with ref non-DONE: stall.
- FSM states:
  - START -> PROCESS on first valid input.
  - PROCESS as above.
  - DONE -> START next cycle, ready for a new tile.
- Root mode (root=1):
  - Ref treated as constant data 0; proc_data_in_ready held 0.
  - repsig R -> push 0.
  - repsig Sk -> push Sk.
  - repsig DONE -> push DONE, go to DONE.
- Simultaneous output pop and push in the same cycle is allowed at full occupancy.
- Reset mid-stream discards FIFO contents and pending stop.

Test Plan:
- Basic repeat: ref [5,7,S0,DONE], repsig [R,R,S0,R,S0,DONE] -> out [5,5,S0,7,S1,DONE] (pending S0 merged into S1).
- Backpressure: same stimulus, ref_data_out_ready toggling every cycle -> identical sequence, no drops or duplicates, FIFO never over 2.
- Root mode: root=1, repsig [R,R,S0,R,DONE] -> out [0,0,S0,0,DONE]; proc_data_in_ready stays 0.
- spacc filter: spacc_mode=1, stop_lvl=2, ref [3,S0,4,S1,DONE], repsig [R,S0,R,S0,DONE] -> out [3,4,DONE].
- Reset/flush mid-stream: assert rst_n=1 after 2 outputs -> valid drops to 0 next cycle; a fresh tile then produces the correct full sequence.
- clk_en=0 for 3 cycles mid-stream -> no handshakes; output resumes unchanged afterwards.

Source files
------------

// File: rtl/sparse_repeat.sv
`default_nettype none
// ============================================================================
// Module  : sparse_repeat
// Brief   : Repeats each reference token once per repeat token (ready/valid).
// Revision: 1.0
// ============================================================================
module sparse_repeat #(
   parameter int DATA_WIDTH     = 16,
   parameter int OUT_FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clk_en,
   input  logic                  flush,
   input  logic                  tile_en,
   input  logic                  root,
   input  logic                  spacc_mode,
   input  logic [15:0]           stop_lvl,
   input  logic [DATA_WIDTH:0]   proc_data_in,
   input  logic                  proc_data_in_valid,
   output logic                  proc_data_in_ready,
   input  logic [DATA_WIDTH:0]   repsig_data_in,
   input  logic                  repsig_data_in_valid,
   output logic                  repsig_data_in_ready,
   output logic [DATA_WIDTH:0]   ref_data_out,
   output logic                  ref_data_out_valid,
   input  logic                  ref_data_out_ready
);

   localparam int c_aw = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
   localparam int c_cw = $clog2(OUT_FIFO_DEPTH + 1);
   localparam logic [c_cw-1:0] c_depth = c_cw'(OUT_FIFO_DEPTH);
   localparam logic [c_aw-1:0] c_last  = c_aw'(OUT_FIFO_DEPTH - 1);
   localparam logic [DATA_WIDTH:0] c_tok_done = {1'b1, DATA_WIDTH'(9'h100)};
   localparam logic [DATA_WIDTH:0] c_tok_s0   = {1'b1, DATA_WIDTH'(0)};

   localparam logic [1:0] c_st_start   = 2'd0;
   localparam logic [1:0] c_st_process = 2'd1;
   localparam logic [1:0] c_st_done    = 2'd2;

   logic [1:0]            state_q, state_d;
   logic                  pend_q, pend_d;
   logic [c_cw-1:0]       count_q, count_d;
   logic [c_aw-1:0]       wr_ptr_q, wr_ptr_d;
   logic [c_aw-1:0]       rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH:0]   mem_q [OUT_FIFO_DEPTH];

   logic                  clr, active, out_valid, out_pop, space, run;
   logic                  ref_data, ref_stop, ref_done;
   logic                  rep_data, rep_stop, rep_done;
   logic                  drop_stop, push, pop_ref, pop_rep, go_done;
   logic [DATA_WIDTH:0]   push_tok;
   logic [7:0]            ref_k;

   assign clr       = rst_n | flush | ~tile_en;
   assign active    = clk_en & ~clr;
   assign out_valid = active & (count_q != '0);
   assign out_pop   = out_valid & ref_data_out_ready;
   assign space     = (count_q < c_depth) | out_pop;
   assign run       = active & (state_q != c_st_done) & space;

   assign ref_k     = proc_data_in[7:0];
   assign ref_data  = ~proc_data_in[DATA_WIDTH];
   assign ref_done  = (proc_data_in == c_tok_done);
   assign ref_stop  = proc_data_in[DATA_WIDTH] & ~proc_data_in[8];
   assign rep_data  = ~repsig_data_in[DATA_WIDTH];
   assign rep_done  = (repsig_data_in == c_tok_done);
   assign rep_stop  = repsig_data_in[DATA_WIDTH] & ~repsig_data_in[8];
   assign drop_stop = spacc_mode & ({8'b0, ref_k} < stop_lvl);

   always_comb begin
      push     = 1'b0;
      push_tok = '0;
      pop_ref  = 1'b0;
      pop_rep  = 1'b0;
      go_done  = 1'b0;
      pend_d   = pend_q;
      if (run) begin
         if (root) begin
            if (repsig_data_in_valid) begin
               if (rep_data) begin
                  push    = 1'b1;
                  pop_rep = 1'b1;
               end else if (rep_stop) begin
                  push     = 1'b1;
                  push_tok = repsig_data_in;
                  pop_rep  = 1'b1;
               end else if (rep_done) begin
                  push     = 1'b1;
                  push_tok = c_tok_done;
                  pop_rep  = 1'b1;
                  go_done  = 1'b1;
               end
            end
         end else if (proc_data_in_valid) begin
            if (ref_stop) begin
               // An upstream stop absorbs any pending S0 and is promoted one level.
               pop_ref = 1'b1;
               pend_d  = 1'b0;
               if (!drop_stop) begin
                  push     = 1'b1;
                  push_tok = {1'b1, (DATA_WIDTH-8)'(0), ref_k + 8'd1};
               end
            end else if (ref_data && pend_q) begin
               push     = 1'b1;
               push_tok = c_tok_s0;
               pend_d   = 1'b0;
            end else if (ref_data && repsig_data_in_valid) begin
               if (rep_data) begin
                  push     = 1'b1;
                  push_tok = {1'b0, proc_data_in[DATA_WIDTH-1:0]};
                  pop_rep  = 1'b1;
               end else if (rep_stop) begin
                  pend_d  = 1'b1;
                  pop_ref = 1'b1;
                  pop_rep = 1'b1;
               end
            end else if (ref_done && repsig_data_in_valid && rep_done) begin
               push = 1'b1;
               if (pend_q) begin
                  push_tok = c_tok_s0;
                  pend_d   = 1'b0;
               end else begin
                  push_tok = c_tok_done;
                  pop_ref  = 1'b1;
                  pop_rep  = 1'b1;
                  go_done  = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_st_start: begin
            if (go_done) begin
               state_d = c_st_done;
            end else if (active && (repsig_data_in_valid || (proc_data_in_valid && !root))) begin
               state_d = c_st_process;
            end
         end
         c_st_process: if (go_done) state_d = c_st_done;
         c_st_done:    if (active) state_d = c_st_start;
         default:      state_d = c_st_start;
      endcase
   end

   always_comb begin
      count_d  = count_q + c_cw'(push) - c_cw'(out_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push)    wr_ptr_d = (wr_ptr_q == c_last) ? '0 : wr_ptr_q + 1'b1;
      if (out_pop) rd_ptr_d = (rd_ptr_q == c_last) ? '0 : rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q  <= c_st_start;
         pend_q   <= 1'b0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_tok;
   end

   assign proc_data_in_ready   = pop_ref;
   assign repsig_data_in_ready = pop_rep;
   assign ref_data_out_valid   = out_valid;
   assign ref_data_out         = (!clr && count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule
`default_nettype wire

// File: tb/tb_sparse_repeat.sv
`default_nettype none
// ============================================================================
// Module  : tb_sparse_repeat
// Brief   : Randomized self-checking bench for sparse_repeat.
// Revision: 1.0
// ============================================================================
module tb_sparse_repeat;

   localparam logic [16:0] c_done = 17'h10100;
   localparam logic [16:0] c_s0   = 17'h10000;
   localparam logic [16:0] c_s1   = 17'h10001;

   logic        clk = 1'b0;
   logic        rst_n, clk_en, flush, tile_en, root, spacc_mode;
   logic [15:0] stop_lvl;
   logic [16:0] proc_data_in, repsig_data_in, ref_data_out;
   logic        proc_data_in_valid, proc_data_in_ready;
   logic        repsig_data_in_valid, repsig_data_in_ready;
   logic        ref_data_out_valid, ref_data_out_ready;

   int tests_run = 0;
   int tests_failed = 0;
   int timed_out, proc_ready_seen, freeze_viol;
   logic [16:0] ref_q[$], rep_q[$], got_q[$], exp_q[$];

   always #5 clk = ~clk;

   sparse_repeat dut (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
      .root(root), .spacc_mode(spacc_mode), .stop_lvl(stop_lvl),
      .proc_data_in(proc_data_in), .proc_data_in_valid(proc_data_in_valid),
      .proc_data_in_ready(proc_data_in_ready),
      .repsig_data_in(repsig_data_in), .repsig_data_in_valid(repsig_data_in_valid),
      .repsig_data_in_ready(repsig_data_in_ready),
      .ref_data_out(ref_data_out), .ref_data_out_valid(ref_data_out_valid),
      .ref_data_out_ready(ref_data_out_ready)
   );

   // Sequence-level reference: walks both token streams and emits the output stream.
   function automatic void build_expected(input bit rt, input bit sp, input int lvl);
      int i, j, k;
      bit pend;
      logic [16:0] t;
      exp_q.delete();
      if (rt) begin
         foreach (rep_q[n]) exp_q.push_back(rep_q[n][16] ? rep_q[n] : 17'h0);
         return;
      end
      pend = 0; i = 0; j = 0;
      while (i < ref_q.size()) begin
         t = ref_q[i];
         if (t == c_done) begin
            if (pend) exp_q.push_back(c_s0);
            exp_q.push_back(c_done);
            break;
         end else if (t[16]) begin
            k = int'(t[7:0]);
            if (!(sp && k < lvl)) exp_q.push_back({1'b1, 8'h00, 8'(k + 1)});
            pend = 0;
            i++;
         end else begin
            if (pend) begin
               exp_q.push_back(c_s0);
               pend = 0;
            end
            if (rep_q[j][16]) begin
               pend = 1;
               i++;
            end else begin
               exp_q.push_back({1'b0, t[15:0]});
            end
            j++;
         end
      end
   endfunction

   task automatic run_stream(input int rdy_mode, input int vld_mode, input int stop_after,
                             input int freeze_at, input int budget);
      int ri = 0, pi = 0, cyc = 0, tail = 0;
      bit acc_p = 0, acc_r = 0, fin = 0;
      got_q.delete();
      timed_out = 0; proc_ready_seen = 0; freeze_viol = 0;
      proc_data_in_valid = 0; repsig_data_in_valid = 0;
      while (!fin) begin
         @(negedge clk);
         if (acc_p) proc_data_in_valid = 0;
         if (acc_r) repsig_data_in_valid = 0;
         acc_p = 0; acc_r = 0;
         clk_en = !(freeze_at >= 0 && cyc >= freeze_at && cyc < freeze_at + 3);
         if (!proc_data_in_valid && ri < ref_q.size() && (vld_mode == 0 || $urandom_range(0, 3) != 0)) begin
            proc_data_in = ref_q[ri];
            proc_data_in_valid = 1;
         end
         if (!repsig_data_in_valid && pi < rep_q.size() && (vld_mode == 0 || $urandom_range(0, 3) != 0)) begin
            repsig_data_in = rep_q[pi];
            repsig_data_in_valid = 1;
         end
         case (rdy_mode)
            0:       ref_data_out_ready = 1;
            1:       ref_data_out_ready = cyc[0];
            default: ref_data_out_ready = ($urandom_range(0, 2) != 0);
         endcase
         #1;
         if (!clk_en && (proc_data_in_ready || repsig_data_in_ready || ref_data_out_valid)) freeze_viol++;
         if (proc_data_in_ready) proc_ready_seen++;
         if (proc_data_in_valid && proc_data_in_ready) begin acc_p = 1; ri++; end
         if (repsig_data_in_valid && repsig_data_in_ready) begin acc_r = 1; pi++; end
         if (ref_data_out_valid && ref_data_out_ready) got_q.push_back(ref_data_out);
         cyc++;
         if (ri >= ref_q.size() && pi >= rep_q.size() && !ref_data_out_valid) tail++;
         if (stop_after > 0 && got_q.size() >= stop_after) fin = 1;
         else if (tail >= 3) fin = 1;
         else if (cyc >= budget) begin timed_out = 1; fin = 1; end
      end
      clk_en = 1;
   endtask

   task automatic load_basic();
      ref_q = '{17'd5, 17'd7, c_s0, c_done};
      rep_q = '{17'd0, 17'd0, c_s0, 17'd0, c_s0, c_done};
      exp_q = '{17'd5, 17'd5, c_s0, 17'd7, c_s1, c_done};
      root = 0; spacc_mode = 0; stop_lvl = 0;
   endtask

   task automatic test_reset();
      rst_n = 1; flush = 0; tile_en = 1; clk_en = 1; root = 0; spacc_mode = 0; stop_lvl = 0;
      proc_data_in = 17'd9; proc_data_in_valid = 1;
      repsig_data_in = 17'd0; repsig_data_in_valid = 1; ref_data_out_ready = 1;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if ({ref_data_out_valid, proc_data_in_ready, repsig_data_in_ready} !== 3'b000 || ref_data_out !== 17'h0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got v/pr/rr=%b%b%b data=%h, want 000 data=0",
                  ref_data_out_valid, proc_data_in_ready, repsig_data_in_ready, ref_data_out);
      end
      @(negedge clk); rst_n = 0; tile_en = 0;
      @(posedge clk); #1;
      tests_run++;
      if ({ref_data_out_valid, proc_data_in_ready, repsig_data_in_ready} !== 3'b000) begin
         tests_failed++;
         $display("FAIL tile_en_hold: got v/pr/rr=%b%b%b, want 000",
                  ref_data_out_valid, proc_data_in_ready, repsig_data_in_ready);
      end
      @(negedge clk); tile_en = 1; proc_data_in_valid = 0; repsig_data_in_valid = 0;
   endtask

   task automatic test_basic();
      load_basic();
      run_stream(0, 0, 0, -1, 300);
      tests_run++;
      if (timed_out || got_q.size() != exp_q.size()) begin
         tests_failed++;
         $display("FAIL basic_len: got %0d tokens (timeout=%0d), want %0d", got_q.size(), timed_out, exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         tests_run++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL basic_tok[%0d]: got %h, want %h", i, (i < got_q.size()) ? got_q[i] : 17'h1ffff, exp_q[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      load_basic();
      run_stream(1, 0, 0, -1, 400);
      tests_run++;
      if (timed_out || got_q.size() != exp_q.size()) begin
         tests_failed++;
         $display("FAIL bp_len: got %0d tokens (timeout=%0d), want %0d", got_q.size(), timed_out, exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         tests_run++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL bp_tok[%0d]: got %h, want %h", i, (i < got_q.size()) ? got_q[i] : 17'h1ffff, exp_q[i]);
         end
      end
   endtask

   task automatic test_root();
      ref_q.delete();
      rep_q = '{17'd3, 17'd4, c_s0, 17'd1, c_done};
      exp_q = '{17'd0, 17'd0, c_s0, 17'd0, c_done};
      root = 1; spacc_mode = 0; stop_lvl = 0;
      run_stream(2, 1, 0, -1, 400);
      tests_run++;
      if (timed_out || got_q.size() != exp_q.size() || proc_ready_seen != 0) begin
         tests_failed++;
         $display("FAIL root_len: got %0d tokens (timeout=%0d, proc_ready=%0d), want %0d, proc_ready=0",
                  got_q.size(), timed_out, proc_ready_seen, exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         tests_run++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL root_tok[%0d]: got %h, want %h", i, (i < got_q.size()) ? got_q[i] : 17'h1ffff, exp_q[i]);
         end
      end
      root = 0;
   endtask

   task automatic test_spacc();
      ref_q = '{17'd3, c_s0, 17'd4, c_s1, c_done};
      rep_q = '{17'd0, c_s0, 17'd0, c_s0, c_done};
      exp_q = '{17'd3, 17'd4, c_done};
      root = 0; spacc_mode = 1; stop_lvl = 16'd2;
      run_stream(0, 0, 0, -1, 300);
      tests_run++;
      if (timed_out || got_q.size() != exp_q.size()) begin
         tests_failed++;
         $display("FAIL spacc_len: got %0d tokens (timeout=%0d), want %0d", got_q.size(), timed_out, exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         tests_run++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL spacc_tok[%0d]: got %h, want %h", i, (i < got_q.size()) ? got_q[i] : 17'h1ffff, exp_q[i]);
         end
      end
      spacc_mode = 0;
   endtask

   task automatic test_mid_clear(input bit use_flush);
      load_basic();
      run_stream(0, 0, 2, -1, 300);
      ref_data_out_ready = 0;
      @(negedge clk);
      proc_data_in_valid = 0; repsig_data_in_valid = 0;
      if (use_flush) flush = 1; else rst_n = 1;
      @(posedge clk); #1;
      tests_run++;
      if ({ref_data_out_valid, proc_data_in_ready, repsig_data_in_ready} !== 3'b000) begin
         tests_failed++;
         $display("FAIL clear_during(flush=%0d): got v/pr/rr=%b%b%b, want 000", use_flush,
                  ref_data_out_valid, proc_data_in_ready, repsig_data_in_ready);
      end
      @(negedge clk); flush = 0; rst_n = 0;
      #1;
      tests_run++;
      if (ref_data_out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL clear_after(flush=%0d): got valid=%b, want 0", use_flush, ref_data_out_valid);
      end
      load_basic();
      run_stream(0, 0, 0, -1, 300);
      tests_run++;
      if (timed_out || got_q.size() != exp_q.size()) begin
         tests_failed++;
         $display("FAIL clear_len(flush=%0d): got %0d tokens, want %0d", use_flush, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         tests_run++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL clear_tok[%0d]: got %h, want %h", i, (i < got_q.size()) ? got_q[i] : 17'h1ffff, exp_q[i]);
         end
      end
   endtask

   task automatic test_clk_en();
      load_basic();
      run_stream(0, 0, 0, 2, 300);
      tests_run++;
      if (freeze_viol != 0 || timed_out || got_q.size() != exp_q.size()) begin
         tests_failed++;
         $display("FAIL clk_en: got %0d handshakes while frozen, %0d tokens, want 0 and %0d",
                  freeze_viol, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         tests_run++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL clk_en_tok[%0d]: got %h, want %h", i, (i < got_q.size()) ? got_q[i] : 17'h1ffff, exp_q[i]);
         end
      end
   endtask

   task automatic test_random();
      bit rt, sp;
      int lvl, n;
      for (int it = 0; it < 24; it++) begin
         rt  = ($urandom_range(0, 3) == 0);
         sp  = $urandom_range(0, 1);
         lvl = $urandom_range(0, 3);
         ref_q.delete(); rep_q.delete();
         n = $urandom_range(2, 8);
         for (int e = 0; e < n; e++) begin
            if (rt) begin
               if ($urandom_range(0, 2) != 0) rep_q.push_back({1'b0, 16'($urandom)});
               else rep_q.push_back({1'b1, 8'h00, 8'($urandom_range(0, 2))});
            end else if ($urandom_range(0, 9) < 7) begin
               ref_q.push_back({1'b0, 16'($urandom)});
               repeat ($urandom_range(0, 3)) rep_q.push_back({1'b0, 16'($urandom)});
               rep_q.push_back(c_s0);
            end else begin
               ref_q.push_back({1'b1, 8'h00, 8'($urandom_range(0, 2))});
            end
         end
         if (!rt) ref_q.push_back(c_done);
         rep_q.push_back(c_done);
         root = rt; spacc_mode = sp; stop_lvl = 16'(lvl);
         build_expected(rt, sp, lvl);
         run_stream(2, 1, 0, -1, 2000);
         tests_run++;
         if (timed_out || got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL rand%0d_len: got %0d tokens (timeout=%0d), want %0d", it, got_q.size(), timed_out, exp_q.size());
         end
         for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
               tests_failed++;
               $display("FAIL rand%0d_tok[%0d]: got %h, want %h", it, i,
                        (i < got_q.size()) ? got_q[i] : 17'h1ffff, exp_q[i]);
            end
         end
      end
      root = 0; spacc_mode = 0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_root();
      test_spacc();
      test_mid_clear(0);
      test_mid_clear(1);
      test_clk_en();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
